// File: rtl/gcd_engine.sv
// gcd_engine: handshake-fed GCD FSMD (Euclid or Stein); define GCD_STATS_EN to add the iter step counter port
module gcd_engine #(
  parameter int W    = 16,
  parameter int ALGO = 0,
  parameter int KW   = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req,
  input  logic [W-1:0] AB,
  output logic         ack,
  output logic [W-1:0] C
`ifdef GCD_STATS_EN
  ,
  output logic [15:0]  iter
`endif
);
  typedef enum logic [2:0] {IDLE, ACK_A, WAIT_B, CALC, DONE} state_t;
  state_t         r_state, w_next;
  logic [W-1:0]   r_a, r_b, w_a, w_b, w_res, w_diff, r_c;
  logic [KW-1:0]  r_k, w_k;
  logic           r_ack, w_term, w_a_ge_b, w_update;
  assign ack      = r_ack;
  assign C        = r_c;
  assign w_a_ge_b = r_a >= r_b;
  assign w_diff   = w_a_ge_b ? r_a - r_b : r_b - r_a;
  assign w_update = (r_state == CALC) && !w_term;
  // next-state, operand updates and terminal result
  always_comb begin
    w_next = r_state;
    w_a    = r_a;
    w_b    = r_b;
    w_k    = r_k;
    w_term = 1'b0;
    w_res  = '0;
    case (r_state)
      IDLE:   if (req) begin
        w_next = ACK_A;
        w_a    = AB;
      end
      ACK_A:  w_next = req ? ACK_A : WAIT_B;
      WAIT_B: if (req) begin
        w_next = CALC;
        w_b    = AB;
        w_k    = '0;
      end
      CALC: begin
        if (r_a == '0) begin
          w_term = 1'b1;
          w_res  = r_b << r_k;
        end else if (r_b == '0) begin
          w_term = 1'b1;
          w_res  = r_a << r_k;
        end else if (ALGO == 0 && r_a == r_b) begin
          w_term = 1'b1;
          w_res  = r_a;
        end else if (ALGO == 0) begin
          w_a = w_a_ge_b ? w_diff : r_a;
          w_b = w_a_ge_b ? r_b : w_diff;
        end else begin
          case ({r_a[0], r_b[0]})
            2'b00: begin
              w_a = r_a >> 1;
              w_b = r_b >> 1;
              w_k = r_k + KW'(1);
            end
            2'b01: w_a = r_a >> 1;
            2'b10: w_b = r_b >> 1;
            default: begin
              w_a = w_a_ge_b ? w_diff >> 1 : r_a;
              w_b = w_a_ge_b ? r_b : w_diff >> 1;
            end
          endcase
        end
        w_next = w_term ? DONE : CALC;
      end
      DONE:    w_next = req ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state, datapath and registered Moore outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_ack   <= 1'b0;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      r_a     <= w_a;
      r_b     <= w_b;
      r_k     <= w_k;
      r_ack   <= (w_next == ACK_A) || (w_next == DONE);
      r_c     <= (w_next != DONE) ? '0 : (r_state == CALC) ? w_res : r_c;
    end
  end
`ifdef GCD_STATS_EN
  logic [15:0] r_iter;
  assign iter = r_iter;
  // saturating count of update steps, cleared when a computation starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_iter <= '0;
    else if (r_state == WAIT_B && req) r_iter <= '0;
    else if (w_update && r_iter != 16'hFFFF) r_iter <= r_iter + 16'd1;
  end
`endif
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: drives Euclid and Stein instances, checks C/ack against an arithmetic GCD model
module tb_gcd_engine;
  localparam int W = 16;
  logic          clk = 1'b0;
  logic          reset_n;
  logic          req [2];
  logic [W-1:0]  ab [2];
  logic          ack [2];
  logic [W-1:0]  c [2];
  logic [W-1:0]  exp_c [2];
  logic          in_result [2];
  int            n_chk = 0;
  int            n_fail = 0;
`ifdef GCD_STATS_EN
  logic [15:0]   it [2];
`endif
  always #5 clk = ~clk;
  gcd_engine #(.W(W), .ALGO(0)) u_euclid (
    .clk(clk), .reset_n(reset_n), .req(req[0]), .AB(ab[0]), .ack(ack[0]), .C(c[0])
`ifdef GCD_STATS_EN
    , .iter(it[0])
`endif
  );
  gcd_engine #(.W(W), .ALGO(1)) u_stein (
    .clk(clk), .reset_n(reset_n), .req(req[1]), .AB(ab[1]), .ack(ack[1]), .C(c[1])
`ifdef GCD_STATS_EN
    , .iter(it[1])
`endif
  );
  function automatic logic [W-1:0] gcd_m(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  // subtractive Euclid step count: sum of division quotients minus the final equal-operands step
  function automatic int sub_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    int s;
    if (a == 0 || b == 0) return 0;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    s = 0;
    while (y != 0) begin
      s += int'(x / y);
      t = x % y;
      x = y;
      y = t;
    end
    return s - 1;
  endfunction
  task automatic chk(input string nm, input logic ok, input longint act, input longint ex);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, ex);
    end
  endtask
  // C must be the model result while ack is high after a B accept, and 0 otherwise
  always @(negedge clk) begin
    if (reset_n) begin
      for (int u = 0; u < 2; u++) begin
        logic [W-1:0] e;
        e = (ack[u] && in_result[u]) ? exp_c[u] : '0;
        n_chk++;
        if (c[u] !== e) begin
          n_fail++;
          $display("FAIL cmp_c unit%0d at %0t: C=%0d expected %0d", u, $time, c[u], e);
        end
      end
    end
  end
  task automatic wait_ack(input int u, input logic v);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack[u] !== v && n < 8);
    chk($sformatf("ack_handshake u%0d", u), ack[u] === v, ack[u], v);
  endtask
  task automatic send_a(input int u, input logic [W-1:0] a);
    ab[u]  = a;
    req[u] = 1'b1;
    wait_ack(u, 1'b1);
    req[u] = 1'b0;
    ab[u]  = W'($urandom);
    wait_ack(u, 1'b0);
  endtask
  task automatic send_b(input int u, input logic [W-1:0] b);
    ab[u]  = b;
    req[u] = 1'b1;
    @(posedge clk);
    #1;
    in_result[u] = 1'b1;
    ab[u] = W'($urandom);
  endtask
  task automatic wait_done(input int u, output int cyc);
    cyc = 0;
    while (ack[u] !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("done_timeout u%0d", u), ack[u] === 1'b1, cyc, 2000);
  endtask
  task automatic run(input int u, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] e, input int lat, input int hold);
    int cyc;
    exp_c[u] = e;
    send_a(u, a);
    send_b(u, b);
    wait_done(u, cyc);
    if (lat >= 0) chk($sformatf("latency u%0d %0d,%0d", u, a, b), cyc == lat, cyc, lat);
    else chk($sformatf("latency_bound u%0d %0d,%0d", u, a, b), cyc <= 2 * W + 1, cyc, 2 * W + 1);
`ifdef GCD_STATS_EN
    chk($sformatf("iter u%0d", u), it[u] == 16'(cyc - 1), it[u], cyc - 1);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ack_hold u%0d", u), ack[u] === 1'b1, ack[u], 1);
    end
    req[u] = 1'b0;
    ab[u]  = W'($urandom);
    @(posedge clk);
    #1;
    chk($sformatf("ack_release u%0d", u), ack[u] === 1'b0, ack[u], 0);
    chk($sformatf("c_release u%0d", u), c[u] == '0, c[u], 0);
    in_result[u] = 1'b0;
`ifdef GCD_STATS_EN
    chk($sformatf("iter_held u%0d", u), it[u] == 16'(cyc - 1), it[u], cyc - 1);
`endif
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    logic [W-1:0] a, b;
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0;
      ab[u] = '0;
      exp_c[u] = '0;
      in_result[u] = 1'b0;
    end
    #3;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_ack u%0d", u), ack[u] === 1'b0, ack[u], 0);
      chk($sformatf("reset_c u%0d", u), c[u] === '0, c[u], 0);
    end
    chk("model_gcd_48_18", gcd_m(16'd48, 16'd18) == 16'd6, gcd_m(16'd48, 16'd18), 6);
    chk("model_steps_48_18", sub_steps(16'd48, 16'd18) == 4, sub_steps(16'd48, 16'd18), 4);
    chk("model_gcd_0_35", gcd_m(16'd0, 16'd35) == 16'd35, gcd_m(16'd0, 16'd35), 35);
    chk("model_gcd_65535_1", gcd_m(16'hFFFF, 16'd1) == 16'd1, gcd_m(16'hFFFF, 16'd1), 1);
    chk("model_steps_300_45", sub_steps(16'd300, 16'd45) == 8, sub_steps(16'd300, 16'd45), 8);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(0, 16'd48, 16'd18, 16'd6, 5, 3);
    run(1, 16'd48, 16'd18, 16'd6, 7, 0);
    run(1, 16'd1024, 16'd1024, 16'd1024, 12, 1);
    for (int u = 0; u < 2; u++) begin
      run(u, 16'd0, 16'd0, 16'd0, 1, 0);
      run(u, 16'd0, 16'd35, 16'd35, 1, 0);
      run(u, 16'd35, 16'd0, 16'd35, 1, 0);
    end
    run(1, 16'hFFFF, 16'd1, 16'd1, 17, 0);
    exp_c[0] = 16'd6;
    send_a(0, 16'd48);
    send_b(0, 16'd18);
    req[0] = 1'b0;
    wait_done(0, cyc);
    chk("violation_latency", cyc == 5, cyc, 5);
    @(posedge clk);
    #1;
    chk("violation_one_cycle_ack", ack[0] === 1'b0, ack[0], 0);
    in_result[0] = 1'b0;
    exp_c[0] = 16'd15;
    send_a(0, 16'd300);
    send_b(0, 16'd45);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    req[0] = 1'b0;
    in_result[0] = 1'b0;
    #1;
    chk("midcalc_reset_ack", ack[0] === 1'b0, ack[0], 0);
    chk("midcalc_reset_c", c[0] === '0, c[0], 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(0, 16'd21, 16'd14, 16'd7, 3, 0);
    exp_c[1] = 16'd6;
    send_a(1, 16'd48);
    send_b(1, 16'd18);
    wait_done(1, cyc);
    reset_n = 1'b0;
    req[1] = 1'b0;
    in_result[1] = 1'b0;
    #1;
    chk("done_async_reset_ack", ack[1] === 1'b0, ack[1], 0);
    chk("done_async_reset_c", c[1] === '0, c[1], 0);
`ifdef GCD_STATS_EN
    chk("done_async_reset_iter", it[1] === 16'd0, it[1], 0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      run(0, a, b, gcd_m(a, b), sub_steps(a, b) + 1, $urandom_range(0, 2));
    end
    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 65535));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 65535));
      if (i % 4 == 0) b = a << $urandom_range(0, 3);
      run(1, a, b, gcd_m(a, b), (a == 0 || b == 0) ? 1 : -1, $urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
